// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   Memory-stage load/store unit. Runs one valid/ready transaction per load or
//   store against a slow backing data memory. It holds the pipeline with StallM
//   until the access completes. It also lane-steers store data and extracts and
//   extends load data.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   MemReadM      load in memory stage (wins when MemWriteM is also set)
//   MemWriteM     store in memory stage
//   Funct3M       access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUOutM       byte address
//   WriteDataM    store data
//   ReadDataM     formatted load data, non-zero only in DONE for loads
//   StallM        freeze IF..MEM while an access is in flight
//   MisalignM     illegal or misaligned access flag (IDLE only)
//   mem_valid     request valid to memory
//   mem_ready     request accepted by memory
//   mem_we        1 = write request
//   mem_addr      word-aligned request address
//   mem_wdata     lane-steered store data
//   mem_wstrb     byte enables
//   mem_rvalid    read response valid
//   mem_rdata     read response word
//
// Handshake: a request is transferred on a rising edge where mem_valid and
// mem_ready are both 1. mem_valid, mem_addr, mem_we, mem_wdata and mem_wstrb
// are held stable from the first REQ cycle until that edge. A read response
// is consumed on a rising edge where mem_rvalid is 1, but only in the WAIT state.
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [ADDR_WIDTH-1:0] ALUOutM,
    input  logic [31:0]           WriteDataM,
    output logic [31:0]           ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;

    logic        access;
    logic        legal;
    logic        misaligned;
    logic        go;
    logic        bad;
    logic [1:0]  lane;
    logic [31:0] steer_wdata;
    logic [3:0]  steer_wstrb;

    // Registered copies of the access; the pipeline inputs are not trusted
    // after the IDLE cycle.
    logic [31:0] rdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        load_q;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // ---------------- request decode ----------------
    assign access = MemReadM | MemWriteM;
    assign lane   = ALUOutM[1:0];

    always_comb begin
        legal = 1'b0;
        if (MemReadM) begin
            legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
                    (Funct3M == 3'b100) || (Funct3M == 3'b101);
        end else if (MemWriteM) begin
            legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
        end
    end

    // Funct3M[1:0]==01 covers both H and HU.
    assign misaligned = ((Funct3M[1:0] == 2'b01) && lane[0]) ||
                        ((Funct3M == 3'b010) && (lane != 2'b00));

    assign go  = access && legal && !misaligned;
    assign bad = access && !(legal && !misaligned);

    // rst gates the combinational flags so the reset value holds even while
    // the pipeline still presents an access.
    assign MisalignM = !rst && (state == IDLE) && bad;
    assign StallM    = !rst && (((state == IDLE) && go) || (state == REQ) || (state == WAIT));

    // ---------------- store steering ----------------
    always_comb begin
        steer_wdata = WriteDataM;
        steer_wstrb = 4'b1111;
        case (Funct3M[1:0])
            2'b00: begin
                steer_wdata = {4{WriteDataM[7:0]}};
                steer_wstrb = 4'b0001 << lane;
            end
            2'b01: begin
                steer_wdata = {2{WriteDataM[15:0]}};
                steer_wstrb = 4'b0011 << lane;
            end
            default: begin
                steer_wdata = WriteDataM;
                steer_wstrb = 4'b1111;
            end
        endcase
    end

    // ---------------- FSM and request registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0;
            mem_addr  <= '0;
            rdata_q   <= 32'h0;
            funct3_q  <= 3'b000;
            lane_q    <= 2'b00;
            load_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= REQ;
                        mem_valid <= 1'b1;
                        mem_we    <= !MemReadM;
                        mem_addr  <= {ALUOutM[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= MemReadM ? 32'h0 : steer_wdata;
                        mem_wstrb <= MemReadM ? 4'b0000 : steer_wstrb;
                        funct3_q  <= Funct3M;
                        lane_q    <= lane;
                        load_q    <= MemReadM;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        state     <= load_q ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- load formatting ----------------
    always_comb begin
        byte_sel = rdata_q[7:0];
        case (lane_q)
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            2'd3:    byte_sel = rdata_q[31:24];
            default: byte_sel = rdata_q[7:0];
        endcase
    end

    assign half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        load_fmt = rdata_q;
        case (funct3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'h0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'h0, half_sel};
            default: load_fmt = rdata_q;
        endcase
    end

    assign ReadDataM = ((state == DONE) && load_q) ? load_fmt : 32'h0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_total;
  int n_bad;

  // results of the last do_access call
  int          o_stall;
  int          o_hs;
  int          o_valid_cyc;
  int          o_first_valid;
  bit          o_done;
  bit          o_stable;
  logic [31:0] o_rd;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_we;

  mem_stage_lsu #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = 3'b000;
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // ---------------- driver ----------------
  // Presents one instruction at posedge+1 and plays the memory side.
  // Memory accepts after ready_dly extra REQ cycles and answers after
  // rvalid_dly extra WAIT cycles. Observations are sampled on the falling edge.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ready_dly, input int rvalid_dly,
                           input logic [31:0] rdata);
    int  valid_cyc;
    int  wait_cyc;
    bit  hs_done;
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUOutM    = addr;
    WriteDataM = wd;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    o_stall = 0; o_hs = 0; o_valid_cyc = 0; o_first_valid = -1;
    o_done = 1'b0; o_stable = 1'b1; o_rd = 32'hx;
    o_addr = 32'hx; o_wdata = 32'hx; o_wstrb = 4'hx; o_we = 1'bx;
    valid_cyc = 0; wait_cyc = 0; hs_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (StallM) o_stall++;
      if (mem_valid) begin
        if (valid_cyc == 0) begin
          o_first_valid = c;
          o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                     mem_wstrb !== o_wstrb || mem_we !== o_we) begin
          o_stable = 1'b0;
        end
        valid_cyc++;
      end
      mem_ready  = mem_valid && (valid_cyc > ready_dly);
      mem_rvalid = 1'b0;
      if (hs_done && StallM && !mem_valid) begin
        if (wait_cyc == rvalid_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
        end
        wait_cyc++;
      end
      if (mem_ready) begin
        o_hs++;
        hs_done = 1'b1;
      end
      if (!StallM && o_stall > 0) begin
        o_done = 1'b1;
        o_rd   = ReadDataM;
        break;
      end
    end
    o_valid_cyc = valid_cyc;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    n_total++; if (StallM !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", StallM); end
    n_total++; if (MisalignM !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", MisalignM); end
    n_total++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", mem_valid); end
    n_total++; if (mem_we !== 1'b0 || mem_wstrb !== 4'b0000) begin n_bad++; $display("FAIL reset_we_wstrb: got %b/%b want 0/0000", mem_we, mem_wstrb); end
    n_total++; if (ReadDataM !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 00000000", ReadDataM); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw_aligned();
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    n_total++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL lw_timeout: done %b want 1", o_done); end
    n_total++; if (o_stall !== 3) begin n_bad++; $display("FAIL lw_stall: got %0d want 3", o_stall); end
    n_total++; if (o_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", o_rd); end
    n_total++; if (o_addr !== 32'h100 || o_we !== 1'b0) begin n_bad++; $display("FAIL lw_req: got addr %h we %b want 00000100 0", o_addr, o_we); end
    n_total++; if (o_hs !== 1) begin n_bad++; $display("FAIL lw_hs: got %0d want 1", o_hs); end
    // slow response: two idle WAIT cycles add two stall cycles
    do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 2, 32'h0BADF00D);
    n_total++; if (o_stall !== 5 || o_rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL lw_slow: got stall %0d data %h want 5 0badf00d", o_stall, o_rd); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3 [6];
    logic [31:0] ad [6];
    logic [31:0] ex [6];
    f3[0] = 3'b000; ad[0] = 32'h103; ex[0] = 32'hFFFFFF80;
    f3[1] = 3'b100; ad[1] = 32'h103; ex[1] = 32'h00000080;
    f3[2] = 3'b001; ad[2] = 32'h102; ex[2] = 32'hFFFF8011;
    f3[3] = 3'b101; ad[3] = 32'h102; ex[3] = 32'h00008011;
    f3[4] = 3'b000; ad[4] = 32'h101; ex[4] = 32'h00000022;
    f3[5] = 3'b001; ad[5] = 32'h100; ex[5] = 32'h00002233;
    for (int i = 0; i < 6; i++) begin
      do_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, 0, 0, 32'h80112233);
      n_total++;
      if (o_rd !== ex[i] || o_addr !== 32'h100 || o_stall !== 3) begin
        n_bad++;
        $display("FAIL load_ext[%0d]: got data %h addr %h stall %0d want %h 00000100 3", i, o_rd, o_addr, o_stall, ex[i]);
      end
    end
  endtask

  task automatic test_store_steer();
    do_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h123456AB, 3, 0, 32'h0);
    n_total++; if (o_valid_cyc !== 4 || o_stable !== 1'b1) begin n_bad++; $display("FAIL sb_hold: got %0d cycles stable %b want 4 1", o_valid_cyc, o_stable); end
    n_total++; if (o_addr !== 32'h200 || o_we !== 1'b1) begin n_bad++; $display("FAIL sb_req: got addr %h we %b want 00000200 1", o_addr, o_we); end
    n_total++; if (o_wdata !== 32'hABABABAB || o_wstrb !== 4'b0010) begin n_bad++; $display("FAIL sb_lane: got %h/%b want abababab/0010", o_wdata, o_wstrb); end
    n_total++; if (o_done !== 1'b1 || o_rd !== 32'h0 || o_stall !== 5) begin n_bad++; $display("FAIL sb_done: got done %b data %h stall %0d want 1 00000000 5", o_done, o_rd, o_stall); end
    do_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h12345678, 0, 0, 32'h0);
    n_total++; if (o_wdata !== 32'h56785678 || o_wstrb !== 4'b1100 || o_stall !== 2) begin n_bad++; $display("FAIL sh_lane: got %h/%b stall %0d want 56785678/1100 2", o_wdata, o_wstrb, o_stall); end
    do_access(1'b0, 1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 1, 0, 32'h0);
    n_total++; if (o_wdata !== 32'hCAFEF00D || o_wstrb !== 4'b1111 || o_addr !== 32'h304) begin n_bad++; $display("FAIL sw_lane: got %h/%b addr %h want cafef00d/1111 00000304", o_wdata, o_wstrb, o_addr); end
    // both read and write set: treated as a load
    do_access(1'b1, 1'b1, 3'b010, 32'h308, 32'hFFFFFFFF, 0, 0, 32'h13579BDF);
    n_total++; if (o_we !== 1'b0 || o_rd !== 32'h13579BDF || o_stall !== 3) begin n_bad++; $display("FAIL rw_is_load: got we %b data %h stall %0d want 0 13579bdf 3", o_we, o_rd, o_stall); end
  endtask

  task automatic test_misalign();
    logic        rd [4];
    logic        wr [4];
    logic [2:0]  f3 [4];
    logic [31:0] ad [4];
    rd[0] = 1; wr[0] = 0; f3[0] = 3'b010; ad[0] = 32'h102;
    rd[1] = 0; wr[1] = 1; f3[1] = 3'b001; ad[1] = 32'h301;
    rd[2] = 1; wr[2] = 0; f3[2] = 3'b011; ad[2] = 32'h100;
    rd[3] = 0; wr[3] = 1; f3[3] = 3'b100; ad[3] = 32'h100;
    for (int i = 0; i < 4; i++) begin
      MemReadM = rd[i]; MemWriteM = wr[i]; Funct3M = f3[i]; ALUOutM = ad[i];
      WriteDataM = 32'h55AA55AA;
      @(negedge clk);
      n_total++;
      if (MisalignM !== 1'b1 || StallM !== 1'b0 || mem_valid !== 1'b0 || ReadDataM !== 32'h0) begin
        n_bad++;
        $display("FAIL misalign[%0d]: got mis %b stall %b valid %b data %h want 1 0 0 00000000", i, MisalignM, StallM, mem_valid, ReadDataM);
      end
      @(posedge clk); #1;
      n_total++;
      if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL misalign_noreq[%0d]: got valid %b want 0", i, mem_valid); end
      idle_inputs();
    end
    @(negedge clk);
    n_total++; if (MisalignM !== 1'b0) begin n_bad++; $display("FAIL misalign_clear: got %b want 0", MisalignM); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int          s1;
    int          h1;
    int          f1;
    logic [31:0] r1;
    do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 32'hA5A5A5A5);
    s1 = o_stall; h1 = o_hs; f1 = o_first_valid; r1 = o_rd;
    do_access(1'b0, 1'b1, 3'b010, 32'h404, 32'h11223344, 0, 0, 32'h0);
    n_total++; if (s1 !== 3 || r1 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL b2b_lw: got stall %0d data %h want 3 a5a5a5a5", s1, r1); end
    n_total++; if (h1 !== 1 || o_hs !== 1) begin n_bad++; $display("FAIL b2b_hs: got %0d/%0d want 1/1", h1, o_hs); end
    n_total++; if (f1 !== 1 || o_first_valid !== 1) begin n_bad++; $display("FAIL b2b_start: got %0d/%0d want 1/1", f1, o_first_valid); end
    n_total++; if (o_stall !== 2 || o_we !== 1'b1 || o_wdata !== 32'h11223344) begin n_bad++; $display("FAIL b2b_sw: got stall %0d we %b wdata %h want 2 1 11223344", o_stall, o_we, o_wdata); end
  endtask

  task automatic test_reset_mid();
    MemReadM = 1'b1; Funct3M = 3'b010; ALUOutM = 32'h500;
    @(posedge clk); #1;            // now REQ
    mem_ready = 1'b1;
    @(posedge clk); #1;            // now WAIT
    mem_ready = 1'b0;
    @(negedge clk);
    n_total++; if (StallM !== 1'b1 || mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pre_wait: got stall %b valid %b want 1 0", StallM, mem_valid); end
    rst = 1'b1;
    #1;
    n_total++; if (StallM !== 1'b0 || mem_valid !== 1'b0 || ReadDataM !== 32'h0) begin n_bad++; $display("FAIL rst_mid: got stall %b valid %b data %h want 0 0 00000000", StallM, mem_valid, ReadDataM); end
    MemReadM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678; mem_ready = 1'b1;
    @(negedge clk);
    n_total++; if (StallM !== 1'b0 || mem_valid !== 1'b0 || ReadDataM !== 32'h0) begin n_bad++; $display("FAIL rst_late_resp: got stall %b valid %b data %h want 0 0 00000000", StallM, mem_valid, ReadDataM); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_total++; if (StallM !== 1'b0 || ReadDataM !== 32'h0) begin n_bad++; $display("FAIL rst_stays_idle: got stall %b data %h want 0 00000000", StallM, ReadDataM); end
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 3'b101, 32'h502, 32'h0, 0, 0, 32'hFEDC0000);
    n_total++; if (o_rd !== 32'h0000FEDC || o_stall !== 3) begin n_bad++; $display("FAIL rst_recover: got data %h stall %0d want 0000fedc 3", o_rd, o_stall); end
  endtask

  // ---------------- main ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_lw_aligned();
    test_load_extract();
    test_store_steer();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Produces ReadDataM for the memory-stage to writeback-stage pipeline register.
- Accepts load and store requests from the memory stage and runs a valid/ready transaction to a slow backing data memory.
- Holds the pipeline with StallM until the access completes.
- Performs byte and halfword lane steering for stores, and extraction plus sign or zero extension for loads.

Parameters:
- ADDR_WIDTH, 32, width of ALUOutM and mem_addr.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  load in memory stage
- MemWriteM  in  1  store in memory stage
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUOutM  in  ADDR_WIDTH  byte address
- WriteDataM  in  32  store data (rs2)
- ReadDataM  out  32  formatted load data, valid in DONE
- StallM  out  1  freeze IF..MEM stages and hold memoryff inputs
- MisalignM  out  1  illegal or misaligned access flag
- mem_valid  out  1  request valid
- mem_ready  in  1  request accepted
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned address (ALUOutM with [1:0] = 0)
- mem_wdata  out  32  lane-steered store data
- mem_wstrb  out  4  byte enables
- mem_rvalid  in  1  read response valid
- mem_rdata  in  32  read response word

Behaviour:
- Reset (async, rst=1): state=IDLE, ReadDataM=0, captured data register=0, StallM=0, MisalignM=0, mem_valid=0, mem_we=0, mem_wstrb=0. This takes effect immediately, mid-transaction included.
- After reset, a late mem_rvalid or mem_ready is ignored in IDLE.
- Access = MemReadM | MemWriteM. If both are 1, the access is a load; mem_we=0.
- Legal accesses:
  - loads: Funct3M in {000, 001, 010, 100, 101}
  - stores: Funct3M in {000, 001, 010}
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
- Illegal or misaligned, in IDLE:
  - MisalignM=1 combinationally, StallM=0, no memory request, ReadDataM=0.
  - The instruction passes through.
- State machine, registered state:
  - IDLE: a legal access gives StallM=1 (combinational), next state REQ. Otherwise StallM=0.
  - REQ:
    - StallM=1, mem_valid=1.
    - mem_addr, mem_we, mem_wdata and mem_wstrb are registered on entry and held stable until mem_ready.
    - mem_ready=1 gives: store → DONE; load → WAIT.
  - WAIT: StallM=1, mem_valid=0. mem_rvalid=1 captures mem_rdata, next state DONE. No timeout.
  - DONE:
    - StallM=0 and ReadDataM = formatted captured data (loads) or 0 (stores).
    - The pipeline advances this cycle, so the memory-stage to writeback-stage register samples ReadDataM.
    - Next state IDLE unconditionally.
    - The new instruction is evaluated next cycle.
- Latency (memory-stage cycles, including the DONE cycle):
  - load: 4 minimum (ready in the first REQ cycle, rvalid in the first WAIT cycle), stall 3.
  - store: 3 minimum, stall 2.
- mem_rvalid in REQ or DONE is ignored; only WAIT consumes a response.
- Store steering by o=addr[1:0]:
  - SB: wdata = byte replicated ×4, wstrb = 0001<<o.
  - SH: wdata = half replicated ×2, wstrb = 0011<<o.
  - SW: wdata as-is, wstrb = 1111.
- Load extraction:
  - B/BU: byte at lane o, sign-extended / zero-extended.
  - H/HU: half at lane o[1]; sign-extended / zero-extended.
  - W: full word.
- ALUOutM, Funct3M and WriteDataM are stable while StallM=1; the unit still uses its registered copies.

Test Plan:
- LW aligned: addr 0x100, rdata 0xDEADBEEF, ready in first REQ cycle, rvalid in first WAIT cycle. Expected: StallM high 3 cycles, ReadDataM=0xDEADBEEF in DONE, mem_addr=0x100, mem_we=0.
- LB/LBU at 0x103, rdata 0x80112233. Expected: LB → 0xFFFFFF80, LBU → 0x00000080. LH at 0x102 → 0xFFFF8011; LHU → 0x00008011.
- SB 0xAB at 0x201, ready delayed 3 cycles. Expected: mem_valid, mem_addr=0x200, mem_wdata=0xABABABAB and mem_wstrb=0010 held for 4 cycles; DONE follows; ReadDataM=0.
- Misaligned LW at 0x102 and SH at 0x301, plus Funct3M=011 load. Expected: MisalignM=1, StallM=0, no mem_valid, ReadDataM=0.
- Back-to-back LW then SW with no gap. Expected: second access starts the cycle after DONE (IDLE → REQ); exactly one mem_valid handshake per instruction.
- rst asserted in WAIT with mem_rvalid arriving 1 cycle after rst falls. Expected: immediate IDLE, StallM=0, mem_valid=0, response ignored, ReadDataM=0.
